// File: rtl/bram_sdp_param.sv
// bram_sdp_param: simple-dual-port RAM with byte enables, optional output register,
// selectable read-during-write behaviour, post-reset clear and out-of-range detection.
module bram_sdp_param #(
    parameter int DATA_W         = 32,
    parameter int BYTE_W         = 8,
    parameter int ADDR_W         = 9,
    parameter int DEPTH          = 501,
    parameter int OUT_REG        = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_en_i,
    input  logic [DATA_W/BYTE_W-1:0]   write_be_i,
    input  logic [ADDR_W-1:0]          write_addr_i,
    input  logic [DATA_W-1:0]          write_data_i,
    input  logic                       read_en_i,
    input  logic [ADDR_W-1:0]          read_addr_i,
    output logic [DATA_W-1:0]          read_data_o,
    output logic                       read_valid_o,
    output logic                       init_busy_o,
    output logic                       addr_err_o
);
    localparam int LANES = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd1_data_q, rd1_data_d;
    logic                rd1_valid_q, rd1_valid_d;
    logic                addr_err_q, addr_err_d;
    logic                ready, wr_oob, rd_oob, wr_go, rd_go, mem_we, bypass;
    logic [LANES-1:0]    mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata, rd_word, rd_merge;

    always_comb begin
        ready       = state_q == ST_READY;
        wr_oob      = {1'b0, write_addr_i} >= DEPTH_X;
        rd_oob      = {1'b0, read_addr_i} >= DEPTH_X;
        wr_go       = ready && write_en_i && !wr_oob;
        rd_go       = ready && read_en_i;
        // The clear sequence borrows the write port with all lanes enabled.
        mem_we      = !ready || wr_go;
        mem_be      = ready ? write_be_i : '1;
        mem_addr    = ready ? write_addr_i : clr_cnt_q;
        mem_wdata   = ready ? write_data_i : '0;
        rd_word     = rd_oob ? '0 : mem_q[read_addr_i];
        rd_merge    = rd_word;
        for (int k = 0; k < LANES; k++)
            if (write_be_i[k]) rd_merge[k*BYTE_W +: BYTE_W] = write_data_i[k*BYTE_W +: BYTE_W];
        bypass      = (RDW_MODE != 0) && wr_go && (write_addr_i == read_addr_i);
        rd1_data_d  = rd_go ? (bypass ? rd_merge : rd_word) : rd1_data_q;
        rd1_valid_d = rd_go;
        addr_err_d  = addr_err_q || (ready && ((write_en_i && wr_oob) || (read_en_i && rd_oob)));
        clr_cnt_d   = ready ? clr_cnt_q : clr_cnt_q + 1'b1;
        state_d     = (!ready && clr_cnt_q == LAST) ? ST_READY : state_q;
    end

    always_ff @(posedge clk)
        for (int k = 0; k < LANES; k++)
            if (mem_we && mem_be[k]) mem_q[mem_addr][k*BYTE_W +: BYTE_W] <= mem_wdata[k*BYTE_W +: BYTE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q   <= '0;
            rd1_data_q  <= '0;
            rd1_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rd1_data_q  <= rd1_data_d;
            rd1_valid_q <= rd1_valid_d;
            addr_err_q  <= addr_err_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] rd2_data_q, rd2_data_d;
        logic              rd2_valid_q;
        always_comb rd2_data_d = rd1_valid_q ? rd1_data_q : rd2_data_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd2_data_q  <= '0;
                rd2_valid_q <= 1'b0;
            end else begin
                rd2_data_q  <= rd2_data_d;
                rd2_valid_q <= rd1_valid_q;
            end
        end
        assign read_data_o  = rd2_data_q;
        assign read_valid_o = rd2_valid_q;
    end else begin : g_noreg
        assign read_data_o  = rd1_data_q;
        assign read_valid_o = rd1_valid_q;
    end

    assign init_busy_o = state_q == ST_CLEAR;
    assign addr_err_o  = addr_err_q;
endmodule

// File: tb/tb_bram_sdp_param.sv
// tb_bram_sdp_param: drives a 2-cycle/old-data RAM and a 1-cycle/new-data RAM in parallel,
// checking read data through per-instance expectation queues.
module tb_bram_sdp_param;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        we, re;
    logic [3:0]  be;
    logic [8:0]  wa, ra;
    logic [31:0] wd, rd0, rd1;
    logic        v0, v1, b0, b1, e0, e1;

    bram_sdp_param u_dut0 (
        .clk(clk), .rst_n(rst_n), .write_en_i(we), .write_be_i(be), .write_addr_i(wa),
        .write_data_i(wd), .read_en_i(re), .read_addr_i(ra), .read_data_o(rd0),
        .read_valid_o(v0), .init_busy_o(b0), .addr_err_o(e0)
    );
    bram_sdp_param #(.OUT_REG(0), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .write_en_i(we), .write_be_i(be), .write_addr_i(wa),
        .write_data_i(wd), .read_en_i(re), .read_addr_i(ra), .read_data_o(rd1),
        .read_valid_o(v1), .init_busy_o(b1), .addr_err_o(e1)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [8:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [8:0]  ra;
        logic [31:0] x0;
        logic [31:0] x1;
    } vec_t;

    vec_t        tv [18];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          checks = 0, errors = 0;
    int          run0 = 0, run1 = 0, best0 = 0, best1 = 0;
    int          n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic sample();
        if (v0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_valid: got valid with data %h, expected no read", rd0);
            end else chk("dut0_read", rd0, q0.pop_front());
        end
        if (v1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_valid: got valid with data %h, expected no read", rd1);
            end else chk("dut1_read", rd1, q1.pop_front());
        end
        run0 = v0 ? run0 + 1 : 0;
        run1 = v1 ? run1 + 1 : 0;
        if (run0 > best0) best0 = run0;
        if (run1 > best1) best1 = run1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            sample();
        end
    endtask

    task automatic op(input logic w, input logic [3:0] bb, input logic [8:0] a, input logic [31:0] d,
                      input logic r, input logic [8:0] b, input logic [31:0] x0, input logic [31:0] x1);
        we = w; be = bb; wa = a; wd = d; re = r; ra = b;
        if (r) begin
            q0.push_back(x0);
            q1.push_back(x1);
        end
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        sample();
    endtask

    // Counts edges until both instances leave the clear state, poking the ports meanwhile.
    task automatic run_clear(input int stop_at, output int cnt);
        cnt = 0;
        while (cnt < 2000) begin
            we = cnt >= 300 && cnt < 304; be = 4'hF; wa = 9'd5; wd = 32'hFFFF_FFFF;
            re = cnt >= 100 && cnt < 104; ra = 9'd5;
            @(posedge clk);
            @(negedge clk);
            sample();
            cnt++;
            if (cnt == stop_at || !b0 || !b1) break;
        end
        we = 1'b0; re = 1'b0;
        if (stop_at == 0) chkb("busy_match", b0, b1);
    endtask

    initial begin
        tv[0]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd0,   32'h0,         32'h0};
        tv[1]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd250, 32'h0,         32'h0};
        tv[2]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd500, 32'h0,         32'h0};
        tv[3]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd5,   32'h0,         32'h0};
        tv[4]  = '{1'b1, 4'hF, 9'd7,   32'hDEADBEEF,  1'b0, 9'd0,   32'h0,         32'h0};
        tv[5]  = '{1'b1, 4'h5, 9'd7,   32'h11223344,  1'b0, 9'd0,   32'h0,         32'h0};
        tv[6]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd7,   32'hDE22BE44,  32'hDE22BE44};
        tv[7]  = '{1'b1, 4'hF, 9'd3,   32'hAAAAAAAA,  1'b0, 9'd0,   32'h0,         32'h0};
        tv[8]  = '{1'b1, 4'hF, 9'd3,   32'h55555555,  1'b1, 9'd3,   32'hAAAAAAAA,  32'h55555555};
        tv[9]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd3,   32'h55555555,  32'h55555555};
        tv[10] = '{1'b1, 4'h0, 9'd10,  32'h12345678,  1'b0, 9'd0,   32'h0,         32'h0};
        tv[11] = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd10,  32'h0,         32'h0};
        tv[12] = '{1'b1, 4'hF, 9'd500, 32'hCAFEF00D,  1'b0, 9'd0,   32'h0,         32'h0};
        tv[13] = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd500, 32'hCAFEF00D,  32'hCAFEF00D};
        tv[14] = '{1'b1, 4'h8, 9'd7,   32'h99000000,  1'b1, 9'd7,   32'hDE22BE44,  32'h9922BE44};
        tv[15] = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd7,   32'h9922BE44,  32'h9922BE44};
        tv[16] = '{1'b1, 4'h1, 9'd3,   32'h12121212,  1'b1, 9'd10,  32'h0,         32'h0};
        tv[17] = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd3,   32'h55555512,  32'h55555512};

        we = 1'b0; re = 1'b0; be = 4'h0; wa = '0; ra = '0; wd = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chkb("rst_valid0", v0, 1'b0);
        chkb("rst_valid1", v1, 1'b0);
        chk("rst_data0", rd0, 32'h0);
        chk("rst_data1", rd1, 32'h0);
        chkb("rst_err0", e0, 1'b0);
        chkb("rst_busy0", b0, 1'b1);
        chkb("rst_busy1", b1, 1'b1);
        rst_n = 1'b1;
        run_clear(0, n);
        chk("clear_cycles", 32'(n), 32'd501);

        foreach (tv[i]) op(tv[i].we, tv[i].be, tv[i].wa, tv[i].wd, tv[i].re, tv[i].ra, tv[i].x0, tv[i].x1);
        idle(2);
        chkb("no_err0", e0, 1'b0);
        chkb("no_err1", e1, 1'b0);

        op(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd7, 32'h9922BE44, 32'h9922BE44);
        chkb("lat_dut1_1cyc", v1, 1'b1);
        chkb("lat_dut0_not_yet", v0, 1'b0);
        idle(1);
        chkb("lat_dut0_2cyc", v0, 1'b1);
        chkb("lat_dut1_pulse", v1, 1'b0);
        idle(1);
        chkb("lat_dut0_pulse", v0, 1'b0);
        chk("hold_dut0", rd0, 32'h9922BE44);
        chk("hold_dut1", rd1, 32'h9922BE44);

        op(1'b1, 4'hF, 9'd505, 32'hDEADDEAD, 1'b0, 9'd0, 32'h0, 32'h0);
        chkb("oob_err0", e0, 1'b1);
        chkb("oob_err1", e1, 1'b1);
        op(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd505, 32'h0, 32'h0);
        op(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd500, 32'hCAFEF00D, 32'hCAFEF00D);
        op(1'b1, 4'hF, 9'd20, 32'h00000020, 1'b1, 9'd20, 32'h0, 32'h00000020);
        idle(2);
        chkb("oob_sticky0", e0, 1'b1);
        chkb("oob_sticky1", e1, 1'b1);

        for (int i = 0; i < 16; i++) op(1'b1, 4'hF, 9'(i), 32'(i * 3), 1'b0, 9'd0, 32'h0, 32'h0);
        run0 = 0; run1 = 0; best0 = 0; best1 = 0;
        for (int i = 0; i < 16; i++) op(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'(i), 32'(i * 3), 32'(i * 3));
        idle(2);
        chk("burst_run0", 32'(best0), 32'd16);
        chk("burst_run1", 32'(best1), 32'd16);

        we = 1'b0; re = 1'b1; ra = 9'd0;
        @(posedge clk);
        @(negedge clk);
        re = 1'b0;
        chkb("inflight_dut1_valid", v1, 1'b1);
        rst_n = 1'b0;
        #1;
        chkb("inflight_dut1_cleared", v1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chkb("inflight_dut0_lost", v0, 1'b0);
        chkb("rst2_err0", e0, 1'b0);
        chkb("rst2_err1", e1, 1'b0);
        chkb("rst2_busy0", b0, 1'b1);
        rst_n = 1'b1;
        run_clear(200, n);
        rst_n = 1'b0;
        #1;
        chkb("midclear_busy0", b0, 1'b1);
        chkb("midclear_valid1", v1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_clear(0, n);
        chk("restart_clear_cycles", 32'(n), 32'd501);

        op(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd15, 32'h0, 32'h0);
        idle(3);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
